store_checkout_tally: RTL and testbench

// - Downstream of the UPC stolen/discount decoder. Consumes its per-item stolen/discounted flags on each scan strobe.
// - Tallies a checkout transaction: item count and discounted-item count.
// - Latches a theft alarm with a blinking LED until a manager acknowledges it. Freezes totals at checkout.

---
 rtl/store_pkg.sv | 10 +
 rtl/store_seg7.sv | 31 +++
 rtl/store_checkout_tally.sv | 212 +++++++++++++++++++++
 tb/tb_store_checkout_tally.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types and constants for the checkout tally block.
package store_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, ALARM, DONE} tally_state_t;

  // Active-low 7-segment patterns, bit order gfedcba.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

endpackage

// File: rtl/store_seg7.sv
// Hex digit (0-F) to active-low 7-segment pattern, bit order gfedcba.
module store_seg7 (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pure lookup; the parent registers the result.
  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/store_checkout_tally.sv
// Checkout transaction tally: synchronised button strobes, IDLE/ACTIVE/ALARM/DONE
// FSM, saturating item/discount counters and a blinking theft alarm.
// Optional STORE_HEX_EN drives hex0/hex1 from item_count; otherwise both are blank.
module store_checkout_tally
  import store_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned BLINK_DIV   = 25_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scan_btn,
  input  logic             ack_btn,
  input  logic             checkout_btn,
  input  logic             clear_btn,
  input  logic             stolen,
  input  logic             discounted,
  output logic [CNT_W-1:0] item_count,
  output logic [CNT_W-1:0] disc_count,
  output logic             alarm,
  output logic             alarm_blink,
  output logic             done,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1
);

  localparam int unsigned NB    = 6;
  localparam int unsigned DIV_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

  // Bit order: 0 scan, 1 ack, 2 checkout, 3 clear, 4 stolen, 5 discounted.
  logic [NB-1:0] raw;
  logic [NB-1:0] sync_q [SYNC_STAGES];
  logic [NB-1:0] sync_d [SYNC_STAGES];
  logic [NB-1:0] sync_last;
  logic [3:0]    edge_q, edge_d, strobe;
  logic [SYNC_STAGES:0] settle_q, settle_d;
  logic          scan_s, ack_s, checkout_s, clear_s, stolen_s, disc_s;

  tally_state_t  state_q, state_d;
  logic          cnt_inc, cnt_clr;
  logic [CNT_W-1:0] item_q, item_d, disc_q, disc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic          blink_q, blink_d;

  assign raw       = {discounted, stolen, clear_btn, checkout_btn, ack_btn, scan_btn};
  assign sync_last = sync_q[SYNC_STAGES-1];

  // Synchroniser shift, edge history and post-reset settle chain.
  // Strobes stay gated until the settle chain shows that both the synchroniser
  // output and the edge history reflect the real inputs, so a button held
  // through reset release never produces a strobe.
  always_comb begin
    sync_d[0] = raw;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    edge_d    = sync_last[3:0];
    settle_d  = {settle_q[SYNC_STAGES-1:0], 1'b1};
    strobe    = sync_last[3:0] & ~edge_q & {4{settle_q[SYNC_STAGES]}};
  end

  assign scan_s     = strobe[0];
  assign ack_s      = strobe[1];
  assign checkout_s = strobe[2];
  assign clear_s    = strobe[3];
  assign stolen_s   = sync_last[4];
  assign disc_s     = sync_last[5];

  // Input conditioning flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      edge_q   <= '0;
      settle_q <= '0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      edge_q   <= edge_d;
      settle_q <= settle_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; priority clear > ack > scan > checkout.
  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan_s) begin
          if (stolen_s) state_d = ALARM;
          else begin
            state_d = ACTIVE;
            cnt_inc = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (clear_s) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (scan_s && stolen_s) begin
          state_d = ALARM;
        end else begin
          // A clean scan coinciding with checkout is still counted.
          if (scan_s)     cnt_inc = 1'b1;
          if (checkout_s) state_d = DONE;
        end
      end
      ALARM: begin
        if (clear_s) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (ack_s) begin
          state_d = (item_q != '0) ? ACTIVE : IDLE;
        end
      end
      DONE: begin
        if (clear_s) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM status outputs.
  always_comb begin
    alarm = (state_q == ALARM);
    done  = (state_q == DONE);
  end

  // Saturating counters and blink divider next values.
  always_comb begin
    item_d = item_q;
    disc_d = disc_q;
    if (cnt_clr) begin
      item_d = '0;
      disc_d = '0;
    end else if (cnt_inc) begin
      if (item_q != '1)           item_d = item_q + CNT_W'(1);
      if (disc_s && disc_q != '1) disc_d = disc_q + CNT_W'(1);
    end

    div_d   = '0;
    blink_d = 1'b0;
    if (state_d == ALARM && state_q != ALARM) begin
      blink_d = 1'b1;
    end else if (state_d == ALARM) begin
      if (div_q == DIV_LAST) begin
        div_d   = '0;
        blink_d = ~blink_q;
      end else begin
        div_d   = div_q + DIV_W'(1);
        blink_d = blink_q;
      end
    end
  end

  // Counter and blink registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      item_q  <= '0;
      disc_q  <= '0;
      div_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      item_q  <= item_d;
      disc_q  <= disc_d;
      div_q   <= div_d;
      blink_q <= blink_d;
    end
  end

  assign item_count  = item_q;
  assign disc_count  = disc_q;
  assign alarm_blink = blink_q;

`ifdef STORE_HEX_EN
  logic [7:0] hex_src;
  logic [6:0] hex0_d, hex1_d, hex0_q, hex1_q;

  assign hex_src = 8'(item_q);

  store_seg7 u_seg_lo (.digit(hex_src[3:0]), .seg(hex0_d));
  store_seg7 u_seg_hi (.digit(hex_src[7:4]), .seg(hex1_d));

  // Display registers, one stage behind item_count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex0_q <= SEG_ZERO;
      hex1_q <= SEG_ZERO;
    end else begin
      hex0_q <= hex0_d;
      hex1_q <= hex1_d;
    end
  end

  assign hex0 = hex0_q;
  assign hex1 = hex1_q;
`else
  assign hex0 = SEG_BLANK;
  assign hex1 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_store_checkout_tally.sv
// Directed self-checking bench for store_checkout_tally (BLINK_DIV=4, SYNC_STAGES=2).
module tb_store_checkout_tally;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scan_btn, ack_btn, checkout_btn, clear_btn, stolen, discounted;
  logic [7:0] item_count, disc_count;
  logic       alarm, alarm_blink, done;
  logic [6:0] hex0, hex1;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef STORE_HEX_EN
  localparam logic [6:0] HEX_RESET = 7'b1000000;
  localparam logic [6:0] HEX_THREE = 7'b0110000;
  localparam logic [6:0] HEX_ZERO  = 7'b1000000;
`else
  localparam logic [6:0] HEX_RESET = 7'b1111111;
  localparam logic [6:0] HEX_THREE = 7'b1111111;
  localparam logic [6:0] HEX_ZERO  = 7'b1111111;
`endif

  store_checkout_tally #(.CNT_W(8), .BLINK_DIV(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .scan_btn(scan_btn), .ack_btn(ack_btn), .checkout_btn(checkout_btn),
    .clear_btn(clear_btn), .stolen(stolen), .discounted(discounted),
    .item_count(item_count), .disc_count(disc_count),
    .alarm(alarm), .alarm_blink(alarm_blink), .done(done),
    .hex0(hex0), .hex1(hex1)
  );

  always #5 clk = ~clk;

  // Raise the chosen buttons together at a negedge, hold, release, then settle.
  task automatic press(input logic sc, input logic ak, input logic co,
                       input logic cl, input logic st, input logic dc);
    stolen = st; discounted = dc;
    scan_btn = sc; ack_btn = ak; checkout_btn = co; clear_btn = cl;
    repeat (5) @(negedge clk);
    scan_btn = 1'b0; ack_btn = 1'b0; checkout_btn = 1'b0; clear_btn = 1'b0;
    repeat (4) @(negedge clk);
    stolen = 1'b0; discounted = 1'b0;
  endtask

  task automatic test_reset;
    scan_btn = 0; ack_btn = 0; checkout_btn = 0; clear_btn = 0;
    stolen = 0; discounted = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (item_count !== 8'd0 || disc_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_counts: got %0d/%0d want 0/0", item_count, disc_count);
    end
    tests_run++;
    if ({alarm, alarm_blink, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 000", {alarm, alarm_blink, done});
    end
    tests_run++;
    if (hex0 !== HEX_RESET || hex1 !== HEX_RESET) begin
      tests_failed++;
      $display("FAIL reset_hex: got %b/%b want %b", hex0, hex1, HEX_RESET);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_count;
    press(1, 0, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0, 1);
    press(1, 0, 0, 0, 0, 0);
    tests_run++;
    if (item_count !== 8'd3 || disc_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL count3: got %0d/%0d want 3/1", item_count, disc_count);
    end
    tests_run++;
    if (hex0 !== HEX_THREE || hex1 !== HEX_ZERO) begin
      tests_failed++;
      $display("FAIL hex3: got %b/%b want %b/%b", hex0, hex1, HEX_THREE, HEX_ZERO);
    end
  endtask

  task automatic test_alarm_blink;
    stolen = 1'b1; scan_btn = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (alarm !== 1'b1 || alarm_blink !== 1'b1) begin
      tests_failed++;
      $display("FAIL alarm_entry: got %b%b want 11", alarm, alarm_blink);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (alarm_blink !== 1'b1) begin
      tests_failed++;
      $display("FAIL blink_hold: got %b want 1", alarm_blink);
    end
    @(negedge clk);
    tests_run++;
    if (alarm_blink !== 1'b0) begin
      tests_failed++;
      $display("FAIL blink_off: got %b want 0", alarm_blink);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (alarm_blink !== 1'b1) begin
      tests_failed++;
      $display("FAIL blink_on: got %b want 1", alarm_blink);
    end
    scan_btn = 1'b0; stolen = 1'b0;
    repeat (4) @(negedge clk);
    press(1, 0, 0, 0, 0, 1);
    press(0, 0, 1, 0, 0, 0);
    tests_run++;
    if (item_count !== 8'd3 || disc_count !== 8'd1 || alarm !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL alarm_drop: got %0d/%0d a=%b d=%b want 3/1 a=1 d=0",
               item_count, disc_count, alarm, done);
    end
    press(0, 1, 0, 0, 0, 0);
    tests_run++;
    if (alarm !== 1'b0 || alarm_blink !== 1'b0 || item_count !== 8'd3) begin
      tests_failed++;
      $display("FAIL ack_active: got a=%b b=%b n=%0d want 0 0 3", alarm, alarm_blink, item_count);
    end
  endtask

  task automatic test_checkout;
    press(0, 0, 1, 0, 0, 0);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL checkout_done: got %b want 1", done);
    end
    press(1, 0, 0, 0, 0, 1);
    press(1, 0, 0, 0, 1, 0);
    tests_run++;
    if (item_count !== 8'd3 || disc_count !== 8'd1 || alarm !== 1'b0 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_frozen: got %0d/%0d a=%b d=%b want 3/1 a=0 d=1",
               item_count, disc_count, alarm, done);
    end
    press(0, 0, 0, 1, 0, 0);
    tests_run++;
    if (done !== 1'b0 || item_count !== 8'd0 || disc_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL clear_done: got d=%b %0d/%0d want d=0 0/0", done, item_count, disc_count);
    end
  endtask

  task automatic test_idle_alarm;
    press(1, 0, 0, 0, 1, 0);
    tests_run++;
    if (alarm !== 1'b1 || item_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL idle_alarm: got a=%b n=%0d want a=1 n=0", alarm, item_count);
    end
    press(0, 1, 0, 0, 0, 0);
    // IDLE ignores checkout, so done must stay low.
    press(0, 0, 1, 0, 0, 0);
    tests_run++;
    if (alarm !== 1'b0 || done !== 1'b0 || item_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL ack_idle: got a=%b d=%b n=%0d want 0 0 0", alarm, done, item_count);
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 256; i++) press(1, 0, 0, 0, 0, 1);
    tests_run++;
    if (item_count !== 8'd255 || disc_count !== 8'd255) begin
      tests_failed++;
      $display("FAIL saturate: got %0d/%0d want 255/255", item_count, disc_count);
    end
    press(1, 0, 0, 0, 1, 0);
    tests_run++;
    if (alarm !== 1'b1 || item_count !== 8'd255) begin
      tests_failed++;
      $display("FAIL sat_alarm: got a=%b n=%0d want a=1 n=255", alarm, item_count);
    end
    press(0, 0, 0, 1, 0, 0);
    tests_run++;
    if (alarm !== 1'b0 || item_count !== 8'd0 || disc_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL alarm_clear: got a=%b %0d/%0d want 0 0/0", alarm, item_count, disc_count);
    end
  endtask

  task automatic test_simultaneous;
    press(1, 0, 0, 0, 0, 0);
    press(1, 0, 0, 0, 1, 0);
    press(1, 1, 0, 0, 0, 1);
    tests_run++;
    if (alarm !== 1'b0 || item_count !== 8'd1 || disc_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL ack_scan: got a=%b %0d/%0d want 0 1/0", alarm, item_count, disc_count);
    end
    press(1, 0, 0, 1, 0, 1);
    tests_run++;
    if (item_count !== 8'd0 || disc_count !== 8'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_scan: got %0d/%0d d=%b want 0/0 d=0", item_count, disc_count, done);
    end
    press(1, 0, 0, 0, 0, 0);
    press(1, 0, 1, 0, 0, 1);
    tests_run++;
    if (item_count !== 8'd2 || disc_count !== 8'd1 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL scan_checkout: got %0d/%0d d=%b want 2/1 d=1", item_count, disc_count, done);
    end
    press(0, 0, 0, 1, 0, 0);
    press(1, 0, 0, 0, 0, 0);
    press(1, 0, 1, 0, 1, 0);
    tests_run++;
    if (alarm !== 1'b1 || done !== 1'b0 || item_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL stolen_checkout: got a=%b d=%b n=%0d want 1 0 1", alarm, done, item_count);
    end
  endtask

  task automatic test_reset_mid;
    tests_run++;
    if (alarm !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_alarm: got %b want 1", alarm);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({alarm, alarm_blink, done} !== 3'b000 || item_count !== 8'd0 || disc_count !== 8'd0
        || hex0 !== HEX_RESET || hex1 !== HEX_RESET) begin
      tests_failed++;
      $display("FAIL async_reset: got flags=%b %0d/%0d hex=%b/%b",
               {alarm, alarm_blink, done}, item_count, disc_count, hex0, hex1);
    end
    scan_btn = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (item_count !== 8'd0 || alarm !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_scan: got n=%0d a=%b want 0 0", item_count, alarm);
    end
    scan_btn = 1'b0;
    repeat (4) @(negedge clk);
    press(1, 0, 0, 0, 0, 0);
    tests_run++;
    if (item_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL rearm_scan: got %0d want 1", item_count);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_count();
    test_alarm_blink();
    test_checkout();
    test_idle_alarm();
    test_saturate();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
